// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage with byte-lane data RAM and MEM/WB register; define DMEM_ALIGN_CHECK_EN to flag and suppress misaligned accesses
module mem_access_stage #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] returnAddressM,
  input  logic [5:0]  opcodeM,
  input  logic [31:0] instrM,
  input  logic        stallW,
  input  logic        flushW,
  output logic [31:0] ResultW,
  output logic [4:0]  WriteRegW,
  output logic        RegWriteW,
  output logic [31:0] instrW,
  output logic        AlignErrW
);
  logic [31:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [1:0] off, ld_off, st_off, off_w;
  logic ld_b, ld_h, st_b, st_h, mis_ld, mis_st, we, mtr_w;
  logic [3:0] be;
  logic [31:0] wdata, rdata, alu_w, ret_w, ld_val;
  logic [5:0] op_w;
  logic [7:0] byte_w;
  logic [15:0] half_w;
  assign idx    = ALUOutM[ADDR_W+1:2];
  assign off    = ALUOutM[1:0];
  assign ld_b   = opcodeM == 6'h20 || opcodeM == 6'h24;
  assign ld_h   = opcodeM == 6'h21 || opcodeM == 6'h25;
  assign st_b   = opcodeM == 6'h28;
  assign st_h   = opcodeM == 6'h29;
  assign ld_off = ld_b ? off : ld_h ? {off[1], 1'b0} : 2'b00;
  assign st_off = st_b ? off : st_h ? {off[1], 1'b0} : 2'b00;
  assign be     = st_b ? 4'b0001 << st_off : st_h ? (st_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata  = st_b ? {4{WriteDataM[7:0]}} : st_h ? {2{WriteDataM[15:0]}} : WriteDataM;
`ifdef DMEM_ALIGN_CHECK_EN
  assign mis_ld = MemtoRegM && (ld_h ? off[0] : !ld_b && off != 2'b00);
  assign mis_st = st_h ? off[0] : !st_b && off != 2'b00;
`else
  assign mis_ld = 1'b0;
  assign mis_st = 1'b0;
`endif
  assign we = MemWriteM && !rst && !flushW && !stallW && !mis_st;
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (!stallW) rdata <= mem[idx];
  end
  always_ff @(posedge clk) begin
    if (rst || flushW) begin
      alu_w     <= '0;
      ret_w     <= '0;
      op_w      <= '0;
      off_w     <= '0;
      mtr_w     <= 1'b0;
      WriteRegW <= '0;
      RegWriteW <= 1'b0;
      instrW    <= '0;
      AlignErrW <= 1'b0;
    end else if (!stallW) begin
      alu_w     <= ALUOutM;
      ret_w     <= returnAddressM;
      op_w      <= opcodeM;
      off_w     <= ld_off;
      mtr_w     <= MemtoRegM;
      WriteRegW <= WriteRegM;
      RegWriteW <= RegWriteM && !mis_ld;
      instrW    <= instrM;
      AlignErrW <= mis_ld;
    end
  end
  assign byte_w  = rdata[8*off_w +: 8];
  assign half_w  = off_w[1] ? rdata[31:16] : rdata[15:0];
  assign ld_val  = op_w == 6'h20 ? {{24{byte_w[7]}}, byte_w} :
                   op_w == 6'h24 ? {24'h0, byte_w} :
                   op_w == 6'h21 ? {{16{half_w[15]}}, half_w} :
                   op_w == 6'h25 ? {16'h0, half_w} : rdata;
  assign ResultW = op_w == 6'h03 ? ret_w : mtr_w ? ld_val : alu_w;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] ALUOutM = '0, WriteDataM = '0, returnAddressM = '0, instrM = '0;
  logic [4:0] WriteRegM = '0;
  logic RegWriteM = 1'b0, MemtoRegM = 1'b0, MemWriteM = 1'b0, stallW = 1'b0, flushW = 1'b0;
  logic [5:0] opcodeM = '0;
  logic [31:0] ResultW, instrW;
  logic [4:0] WriteRegW;
  logic RegWriteW, AlignErrW;
  int compared = 0, mismatched = 0;
  mem_access_stage dut (
    .clk(clk), .rst(rst), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .returnAddressM(returnAddressM), .opcodeM(opcodeM), .instrM(instrM), .stallW(stallW),
    .flushW(flushW), .ResultW(ResultW), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .instrW(instrW), .AlignErrW(AlignErrW)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [5:0] opc, input logic mw, input logic mtr, input logic rw,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wr);
    opcodeM = opc;
    MemWriteM = mw;
    MemtoRegM = mtr;
    RegWriteM = rw;
    ALUOutM = addr;
    WriteDataM = wd;
    WriteRegM = wr;
    instrM = {opc, 26'(addr)};
    @(posedge clk);
    #1;
  endtask
  initial begin
    step(6'h2B, 1'b1, 1'b0, 1'b1, 32'h40, 32'hDEAD_0000, 5'd3);
    step(6'h2B, 1'b1, 1'b0, 1'b1, 32'h40, 32'hDEAD_0000, 5'd3);
    chk("rst_result", ResultW, 32'h0);
    chk("rst_regwrite", RegWriteW, 32'h0);
    chk("rst_alignerr", AlignErrW, 32'h0);
    chk("rst_writereg", WriteRegW, 32'h0);
    chk("rst_instr", instrW, 32'h0);
    rst = 1'b0;
    step(6'h2B, 1'b1, 1'b0, 1'b0, 32'h10, 32'h8000_0001, 5'd0);
    step(6'h23, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd5);
    chk("lw_raw", ResultW, 32'h8000_0001);
    chk("lw_regwrite", RegWriteW, 32'h1);
    chk("lw_writereg", WriteRegW, 32'd5);
    chk("lw_instr", instrW, {6'h23, 26'h10});
    step(6'h2B, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 5'd0);
    step(6'h28, 1'b1, 1'b0, 1'b0, 32'h22, 32'h1234_56F5, 5'd0);
    step(6'h20, 1'b0, 1'b1, 1'b1, 32'h22, 32'h0, 5'd6);
    chk("lb_sext", ResultW, 32'hFFFF_FFF5);
    step(6'h24, 1'b0, 1'b1, 1'b1, 32'h22, 32'h0, 5'd6);
    chk("lbu_zext", ResultW, 32'h0000_00F5);
    step(6'h23, 1'b0, 1'b1, 1'b1, 32'h20, 32'h0, 5'd6);
    chk("lw_after_sb", ResultW, 32'h00F5_0000);
    step(6'h2B, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 5'd0);
    step(6'h29, 1'b1, 1'b0, 1'b0, 32'h32, 32'hABCD_8001, 5'd0);
    step(6'h21, 1'b0, 1'b1, 1'b1, 32'h32, 32'h0, 5'd8);
    chk("lh_sext", ResultW, 32'hFFFF_8001);
    step(6'h25, 1'b0, 1'b1, 1'b1, 32'h32, 32'h0, 5'd8);
    chk("lhu_zext", ResultW, 32'h0000_8001);
    step(6'h23, 1'b0, 1'b1, 1'b1, 32'h31, 32'h0, 5'd8);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("lw_mis_alignerr", AlignErrW, 32'h1);
    chk("lw_mis_regwrite", RegWriteW, 32'h0);
`else
    chk("lw_forced_align", ResultW, 32'h8001_0000);
    chk("lw_forced_alignerr", AlignErrW, 32'h0);
    step(6'h21, 1'b0, 1'b1, 1'b1, 32'h33, 32'h0, 5'd8);
    chk("lh_forced_align", ResultW, 32'hFFFF_8001);
`endif
    step(6'h2B, 1'b1, 1'b0, 1'b0, 32'h0000_1014, 32'h0000_0077, 5'd0);
    step(6'h23, 1'b0, 1'b1, 1'b1, 32'h14, 32'h0, 5'd9);
    chk("addr_wrap", ResultW, 32'h0000_0077);
    step(6'h2B, 1'b1, 1'b0, 1'b0, 32'h54, 32'h4444_4444, 5'd0);
    step(6'h00, 1'b0, 1'b0, 1'b1, 32'hAAAA, 32'h0, 5'd7);
    chk("alu_result", ResultW, 32'hAAAA);
    stallW = 1'b1;
    step(6'h2B, 1'b1, 1'b0, 1'b0, 32'h54, 32'h3333_3333, 5'd0);
    chk("stall1_result", ResultW, 32'hAAAA);
    chk("stall1_writereg", WriteRegW, 32'd7);
    step(6'h2B, 1'b1, 1'b0, 1'b0, 32'h54, 32'h3333_3333, 5'd0);
    chk("stall2_result", ResultW, 32'hAAAA);
    chk("stall2_regwrite", RegWriteW, 32'h1);
    stallW = 1'b0;
    step(6'h23, 1'b0, 1'b1, 1'b1, 32'h54, 32'h0, 5'd10);
    chk("stalled_store_dropped", ResultW, 32'h4444_4444);
    stallW = 1'b1;
    step(6'h2B, 1'b1, 1'b0, 1'b0, 32'h50, 32'h2222_2222, 5'd0);
    step(6'h2B, 1'b1, 1'b0, 1'b0, 32'h50, 32'h2222_2222, 5'd0);
    stallW = 1'b0;
    step(6'h2B, 1'b1, 1'b0, 1'b0, 32'h50, 32'h2222_2222, 5'd0);
    step(6'h23, 1'b0, 1'b1, 1'b1, 32'h50, 32'h0, 5'd10);
    chk("store_after_stall", ResultW, 32'h2222_2222);
    flushW = 1'b1;
    step(6'h2B, 1'b1, 1'b0, 1'b1, 32'h50, 32'h5555_5555, 5'd9);
    chk("flush_regwrite", RegWriteW, 32'h0);
    chk("flush_instr", instrW, 32'h0);
    chk("flush_alignerr", AlignErrW, 32'h0);
    flushW = 1'b0;
    step(6'h23, 1'b0, 1'b1, 1'b1, 32'h50, 32'h0, 5'd10);
    chk("flushed_store_dropped", ResultW, 32'h2222_2222);
    returnAddressM = 32'h0040_0008;
    step(6'h03, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 5'd31);
    chk("jal_result", ResultW, 32'h0040_0008);
    chk("jal_regwrite", RegWriteW, 32'h1);
    chk("jal_writereg", WriteRegW, 32'd31);
    returnAddressM = 32'h0;
    step(6'h2B, 1'b1, 1'b0, 1'b0, 32'h40, 32'hCAFE_F00D, 5'd0);
    rst = 1'b1;
    step(6'h2B, 1'b1, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 5'd4);
    chk("rst2_result", ResultW, 32'h0);
    chk("rst2_regwrite", RegWriteW, 32'h0);
    chk("rst2_writereg", WriteRegW, 32'h0);
    chk("rst2_instr", instrW, 32'h0);
    rst = 1'b0;
    step(6'h23, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd11);
    chk("rst_store_dropped", ResultW, 32'hCAFE_F00D);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
